sm_result_display: RTL and testbench

SM_RESULT_DISPLAY -- requirements
Module: sm_result_display

---
 rtl/sm_result_display.sv | 175 +++++++++++++++++
 tb/tb_sm_result_display.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sm_result_display.sv
// rtl/sm_result_display.sv - ALU result to 3-digit multiplexed 7-segment display via serial BCD conversion.
// Define SM_BLANK_LEAD_ZERO_EN to blank a zero tens digit.
module sm_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] mag,
  input  logic       cout,
  input  logic       sign,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    step;
  logic [12:0]   sr;
  logic [12:0]   sr_adj;
  logic [12:0]   sr_nxt;
  logic [3:0]    adj_t;
  logic [3:0]    adj_u;
  logic          neg_pend;
  logic          conv_last;
  logic          accept;

  logic          disp_valid;
  logic [3:0]    disp_tens;
  logic [3:0]    disp_units;
  logic          disp_neg;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          show;
  logic [6:0]    tens_seg;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  assign conv_last = (state == CONV) && (step == 3'd4);
  assign accept    = load && (state != CONV);

  // sr = {tens, units, remaining binary}; add-3 correction precedes each shift.
  always_comb begin
    adj_t  = (sr[12:9] >= 4'd5) ? sr[12:9] + 4'd3 : sr[12:9];
    adj_u  = (sr[8:5]  >= 4'd5) ? sr[8:5]  + 4'd3 : sr[8:5];
    sr_adj = {adj_t, adj_u, sr[4:0]};
    sr_nxt = sr_adj << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (load) state_nxt = CONV;
      CONV: begin
        busy = 1'b1;
        if (step == 3'd4) state_nxt = SHOW;
      end
      SHOW: if (load) state_nxt = CONV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step       <= 3'd0;
      sr         <= 13'd0;
      neg_pend   <= 1'b0;
      done       <= 1'b0;
      disp_valid <= 1'b0;
      disp_tens  <= 4'd0;
      disp_units <= 4'd0;
      disp_neg   <= 1'b0;
    end else begin
      done <= conv_last;
      if (accept) begin
        sr       <= {8'd0, cout, mag};
        step     <= 3'd0;
        neg_pend <= sign && ({cout, mag} != 5'd0);
      end else if (state == CONV) begin
        sr   <= sr_nxt;
        step <= step + 3'd1;
        if (conv_last) begin
          disp_valid <= 1'b1;
          disp_tens  <= sr_nxt[12:9];
          disp_units <= sr_nxt[8:5];
          disp_neg   <= neg_pend;
        end
      end
    end
  end

  // Free-running scan, never realigned by load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
`ifdef SM_BLANK_LEAD_ZERO_EN
    tens_seg = (disp_tens == 4'd0) ? SEG_BLANK : enc(disp_tens);
`else
    tens_seg = enc(disp_tens);
`endif
  end

  assign show = (state != IDLE) && disp_valid;

  always_comb begin
    an  = 3'b111;
    seg = SEG_BLANK;
    if (show) begin
      case (idx)
        2'd0: begin
          an  = 3'b110;
          seg = enc(disp_units);
        end
        2'd1: begin
          an  = 3'b101;
          seg = tens_seg;
        end
        2'd2: begin
          an  = 3'b011;
          seg = disp_neg ? SEG_MINUS : SEG_BLANK;
        end
        default: begin
          an  = 3'b111;
          seg = SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_result_display.sv
// tb/tb_sm_result_display.sv - scoreboard bench for sm_result_display with random and directed loads.
module tb_sm_result_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] mag;
  logic       cout;
  logic       sign;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [2:0] an;

  sm_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .mag(mag), .cout(cout), .sign(sign),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int tens;
    int units;
    bit neg;
  } exp_t;

  exp_t q[$];
  exp_t shown;
  bit   shown_valid = 1'b0;
  bit   started = 1'b0;
  int   k = 0;
  int   conv_left = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: acceptance and timing by cycle arithmetic.
  always @(posedge clk) begin
    int v;
    if (!rst_n) begin
      k = 0;
      conv_left = 0;
      shown_valid = 1'b0;
      q.delete();
      started = 1'b1;
    end else begin
      k++;
      if (conv_left > 0) begin
        conv_left--;
      end else if (load) begin
        v = {cout, mag};
        conv_left = 5;
        q.push_back('{due: k + 5, tens: v / 10, units: v % 10, neg: sign && (v != 0)});
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    bit exp_done;
    int sel;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    if (started) begin
      exp_done = (q.size() > 0) && (q[0].due == k);
      chk("done", int'(done), int'(exp_done));
      if (exp_done) begin
        shown = q.pop_front();
        shown_valid = 1'b1;
      end
      chk("busy", int'(busy), int'(conv_left > 0));
      exp_an  = 3'b111;
      exp_seg = 7'b1111111;
      if (shown_valid) begin
        sel = (k / DIV) % 3;
        case (sel)
          0: begin exp_an = 3'b110; exp_seg = digit_code(shown.units); end
          1: begin
            exp_an = 3'b101;
`ifdef SM_BLANK_LEAD_ZERO_EN
            exp_seg = (shown.tens == 0) ? 7'b1111111 : digit_code(shown.tens);
`else
            exp_seg = digit_code(shown.tens);
`endif
          end
          default: begin exp_an = 3'b011; exp_seg = shown.neg ? 7'b0111111 : 7'b1111111; end
        endcase
      end
      chk("an", int'(an), int'(exp_an));
      chk("seg", int'(seg), int'(exp_seg));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic c, input logic [3:0] m, input logic s);
    @(negedge clk);
    load = 1'b1; cout = c; mag = m; sign = s;
    @(negedge clk);
    load = 1'b0;
    cout = 1'($urandom); mag = 4'($urandom); sign = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; cout = 1'b1; mag = 4'd7; sign = 1'b1;
    cycles(2);
    load = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(5);
    // -23, then a long SHOW window for the scan order
    do_load(1'b1, 4'b0111, 1'b1);
    cycles(32);
    // negative zero
    do_load(1'b0, 4'b0000, 1'b1);
    cycles(16);
    // 31 then 5 two cycles later, which must be dropped
    do_load(1'b1, 4'b1111, 1'b0);
    do_load(1'b0, 4'b0101, 1'b0);
    cycles(16);
    // reset during the third conversion cycle
    do_load(1'b0, 4'b1001, 1'b1);
    cycles(2);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(14);
    // 12 then 9: old value stays up through the conversion
    do_load(1'b0, 4'b1100, 1'b0);
    cycles(12);
    do_load(1'b0, 4'b1001, 1'b0);
    cycles(16);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        load = 1'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b0;
      end else begin
        do_load(1'($urandom), 4'($urandom), 1'($urandom));
      end
      cycles(int'($urandom_range(0, 9)));
    end
    cycles(12);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
